// File: rtl/ascon_ti_pkg.sv
// ascon_ti_pkg: shared types, constants and helpers for the TI Ascon permutation
package ascon_ti_pkg;
  typedef logic [4:0][63:0] st_t;
  typedef enum logic [1:0] {IDLE, SBOX, LIN, DONE} state_t;
  localparam int X0 = 0, X1 = 1, X2 = 2, X3 = 3, X4 = 4;
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};
  function automatic logic [7:0] ROUND_CONST(input logic [3:0] i);
    return {4'hf - i, i};
  endfunction
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
endpackage

// File: rtl/ascon_ti_perm_ctrl_if.sv
// ascon_ti_perm_ctrl_if: request/result handshake and share buses of the permutation controller
interface ascon_ti_perm_ctrl_if;
  import ascon_ti_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] rounds_i;
  st_t s0_i, s1_i, s2_i, s0_o, s1_o, s2_o;
  modport master (output in_valid, rounds_i, s0_i, s1_i, s2_i, out_ready,
                  input in_ready, out_valid, s0_o, s1_o, s2_o, busy);
  modport slave (input in_valid, rounds_i, s0_i, s1_i, s2_i, out_ready,
                 output in_ready, out_valid, s0_o, s1_o, s2_o, busy);
endinterface

// File: rtl/ascon_ti_linear.sv
// ascon_ti_linear: Ascon linear diffusion layer applied to one share
module ascon_ti_linear
  import ascon_ti_pkg::*;
(
  input  st_t x,
  output st_t y
);
  for (genvar k = 0; k < 5; k++) begin : g_w
    assign y[k] = x[k] ^ ror(x[k], ROT_A[k]) ^ ror(x[k], ROT_B[k]);
  end
endmodule

// File: rtl/sub_layer_ti.sv
// sub_layer_ti: TI share functions of the Ascon substitution layer; share j sees input shares j and j+1 only
module ascon_ti_share_fn
  import ascon_ti_pkg::*;
#(
  parameter bit P0 = 1'b0,
  parameter bit Q0 = 1'b0,
  parameter bit OUT0 = 1'b0
) (
  input  st_t p,
  input  st_t q,
  output st_t y
);
  st_t up, uq, v;
  function automatic st_t pre(input st_t x);
    pre = x;
    pre[X0] = x[X0] ^ x[X4];
    pre[X4] = x[X4] ^ x[X3];
    pre[X2] = x[X2] ^ x[X1];
  endfunction
  // the chi complement is carried by whichever input is share 0
  always_comb begin
    up = pre(p);
    uq = pre(q);
    v = '0;
    for (int i = 0; i < 5; i++)
      v[i] = up[i] ^ ((up[(i+1)%5] ^ {64{P0}}) & (up[(i+2)%5] ^ uq[(i+2)%5]))
                   ^ ((uq[(i+1)%5] ^ {64{Q0}}) & up[(i+2)%5]);
    y = v;
    y[X1] = v[X1] ^ v[X0];
    y[X0] = v[X0] ^ v[X4];
    y[X3] = v[X3] ^ v[X2];
    y[X2] = v[X2] ^ {64{OUT0}};
  end
endmodule

module sub_layer_ti_0 import ascon_ti_pkg::*; (input st_t a, input st_t b, output st_t y);
  ascon_ti_share_fn #(.P0(1'b1), .Q0(1'b0), .OUT0(1'b1)) u_fn (.p(a), .q(b), .y(y));
endmodule

module sub_layer_ti_1 import ascon_ti_pkg::*; (input st_t a, input st_t b, output st_t y);
  ascon_ti_share_fn #(.P0(1'b0), .Q0(1'b0), .OUT0(1'b0)) u_fn (.p(a), .q(b), .y(y));
endmodule

module sub_layer_ti_2 import ascon_ti_pkg::*; (input st_t a, input st_t b, output st_t y);
  ascon_ti_share_fn #(.P0(1'b0), .Q0(1'b1), .OUT0(1'b0)) u_fn (.p(a), .q(b), .y(y));
endmodule

// File: rtl/ascon_ti_perm_ctrl.sv
// ascon_ti_perm_ctrl: round sequencer for the three-share TI Ascon permutation
module ascon_ti_perm_ctrl
  import ascon_ti_pkg::*;
#(
  parameter int MAX_ROUNDS = 12
) (
  input logic clk,
  input logic rst_n,
  ascon_ti_perm_ctrl_if.slave bus
);
  state_t state, state_n;
  st_t s0, s1, s2, x0, y0, y1, y2, t0, t1, t2, l0, l1, l2;
  logic [3:0] rnd, rnd_init;
  logic last;
  assign last = rnd == 4'(MAX_ROUNDS - 1);
  assign rnd_init = (bus.rounds_i == 4'd0 || int'(bus.rounds_i) > MAX_ROUNDS) ? 4'd0
                  : 4'(MAX_ROUNDS - int'(bus.rounds_i));
  always_comb begin
    x0 = s0;
    x0[X2] = s0[X2] ^ {56'd0, ROUND_CONST(rnd)};
  end
  sub_layer_ti_0 u_sb0 (.a(x0), .b(s1), .y(y0));
  sub_layer_ti_1 u_sb1 (.a(s1), .b(s2), .y(y1));
  sub_layer_ti_2 u_sb2 (.a(s2), .b(x0), .y(y2));
  ascon_ti_linear u_lin0 (.x(t0), .y(l0));
  ascon_ti_linear u_lin1 (.x(t1), .y(l1));
  ascon_ti_linear u_lin2 (.x(t2), .y(l2));
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.in_valid ? SBOX : IDLE;
      SBOX: state_n = LIN;
      LIN:  state_n = last ? DONE : SBOX;
      DONE: state_n = bus.out_ready ? IDLE : DONE;
    endcase
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.s0_o = s0;
  assign bus.s1_o = s1;
  assign bus.s2_o = s2;
  // sbox outputs are always registered before reaching the share registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rnd <= '0;
      {s0, s1, s2, t0, t1, t2} <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.in_valid) begin
        {s0, s1, s2} <= {bus.s0_i, bus.s1_i, bus.s2_i};
        rnd <= rnd_init;
      end
      if (state == SBOX) {t0, t1, t2} <= {y0, y1, y2};
      if (state == LIN) begin
        {s0, s1, s2} <= {l0, l1, l2};
        rnd <= rnd + 4'd1;
      end
    end
  end
endmodule
